// File: rtl/s2p_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receiver.
package s2p_pkg;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned LEN_W = 4;
   localparam int unsigned CNT_W = LEN_W + 1;

   typedef enum logic [0:0] {
      S_IDLE,
      S_SHIFT
   } state_e;

endpackage

// File: rtl/s2p_hold.sv
// One-deep valid/ready holding register; flags a sticky overrun when a word
// arrives while the previous one is still unconsumed.
module s2p_hold #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   // Next-state: load wins over accept; an accept on the load edge frees the slot.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (load) begin
         if (!valid_q || ready) begin
            data_d  = load_data;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_out = data_q;
   assign valid    = valid_q;
   assign overrun  = overrun_q;

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: MSB-first frames of 1..WIDTH bits are assembled
// into a left-justified word and handed to a one-deep output buffer.
module s2p_rx #(
   parameter int unsigned WIDTH = s2p_pkg::WIDTH,
   parameter int unsigned LEN_W = s2p_pkg::LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data_in,
   input  logic             enable,
   input  logic [LEN_W-1:0] len,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             overrun
);

   import s2p_pkg::*;

   localparam int unsigned CntW = LEN_W + 1;

   state_e           state_q, state_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CntW-1:0]  frame_len_q, frame_len_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;

   logic [CntW-1:0]  len_ext;
   logic [CntW-1:0]  cnt_inc;
   logic [LEN_W-1:0] pos;
   logic [CntW-1:0]  flen_cur;
   logic [WIDTH-1:0] word_mask;
   logic [WIDTH-1:0] word;
   logic             done;

   // len of 0 stands for a full-width frame.
   assign len_ext = (len == '0) ? CntW'(WIDTH) : {1'b0, len};
   assign cnt_inc = bit_cnt_q + 1'b1;
   // Only used in SHIFT, where bit_cnt is 1..WIDTH-1, so this never underflows.
   assign pos     = LEN_W'(WIDTH - 1) - bit_cnt_q[LEN_W-1:0];

   // FSM next-state, shift-register update and completion detection.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      frame_len_d = frame_len_q;
      shreg_d     = shreg_q;
      flen_cur    = frame_len_q;
      done        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               shreg_d[WIDTH-1] = data_in;
               frame_len_d      = len_ext;
               flen_cur         = len_ext;
               if (len_ext == CntW'(1)) begin
                  done      = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  state_d   = S_SHIFT;
                  bit_cnt_d = CntW'(1);
               end
            end
         end
         S_SHIFT: begin
            if (enable) begin
               shreg_d[pos] = data_in;
               if (cnt_inc == frame_len_q) begin
                  done      = 1'b1;
                  state_d   = S_IDLE;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = cnt_inc;
               end
            end else begin
               // Abort: partial frame is simply dropped.
               state_d   = S_IDLE;
               bit_cnt_d = '0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
         end
      endcase
   end

   // Stale bits left over from earlier frames sit below the frame; clear them.
   always_comb begin
      word_mask = ~({WIDTH{1'b1}} >> flen_cur);
      word      = shreg_d & word_mask;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         frame_len_q <= '0;
         shreg_q     <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_len_q <= frame_len_d;
         shreg_q     <= shreg_d;
      end
   end

   s2p_hold #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (done),
      .load_data(word),
      .ready    (ready),
      .data_out (data_out),
      .valid    (valid),
      .overrun  (overrun)
   );

endmodule

// File: tb/tb_s2p_rx.sv
// Self-checking bench for s2p_rx: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a frame-level model.
module tb_s2p_rx;

   logic        clk;
   logic        reset;
   logic        data_in;
   logic        enable;
   logic [3:0]  len;
   logic [15:0] data_out;
   logic        valid;
   logic        ready;
   logic        overrun;

   int total;
   int bad;
   bit chk_en;

   // Frame-level reference model state.
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_ovf;
   bit          m_in;
   int          m_cnt;
   int          m_flen;
   int          m_acc;

   s2p_rx dut (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_in),
      .enable  (enable),
      .len     (len),
      .data_out(data_out),
      .valid   (valid),
      .ready   (ready),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: accumulate bits arithmetically, left-justify on completion.
   always @(posedge clk) begin
      bit          in_f;
      int          cnt;
      int          flen;
      int          acc;
      bit          complete;
      logic [15:0] word;
      logic        v;
      logic [15:0] d;
      logic        o;
      in_f = m_in; cnt = m_cnt; flen = m_flen; acc = m_acc;
      v = m_valid; d = m_data; o = m_ovf;
      complete = 1'b0;
      word = '0;
      if (!reset) begin
         in_f = 1'b0; cnt = 0; flen = 0; acc = 0;
         v = 1'b0; d = '0; o = 1'b0;
      end else begin
         if (enable) begin
            if (!in_f) begin
               flen = (len == 4'd0) ? 16 : int'(len);
               acc  = int'(data_in);
               cnt  = 1;
               in_f = 1'b1;
            end else begin
               acc = acc * 2 + int'(data_in);
               cnt = cnt + 1;
            end
            if (cnt == flen) begin
               complete = 1'b1;
               word     = 16'((acc << (16 - flen)) & 32'hFFFF);
               in_f     = 1'b0;
               cnt      = 0;
            end
         end else begin
            in_f = 1'b0;
            cnt  = 0;
         end
         if (complete) begin
            if (!v || ready) begin
               d = word;
               v = 1'b1;
            end else begin
               o = 1'b1;
            end
         end else if (v && ready) begin
            v = 1'b0;
         end
      end
      m_in <= in_f; m_cnt <= cnt; m_flen <= flen; m_acc <= acc;
      m_valid <= v; m_data <= d; m_ovf <= o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at a negedge, return at the next negedge.
   task automatic step(input logic rn, input logic en, input logic d, input logic [3:0] l,
                       input logic r);
      reset   = rn;
      enable  = en;
      data_in = d;
      len     = l;
      ready   = r;
      @(negedge clk);
   endtask

   task automatic frame(input logic [3:0] l, input logic [15:0] bits, input int n,
                        input logic r);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, bits[15-i], l, r);
   endtask

   initial begin
      total = 0; bad = 0; chk_en = 1'b0;
      reset = 1'b0; enable = 1'b0; data_in = 1'b0; len = '0; ready = 1'b0;
      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               chk("model_valid", 32'(valid), 32'(m_valid));
               chk("model_data", 32'(data_out), 32'(m_data));
               chk("model_overrun", 32'(overrun), 32'(m_ovf));
            end
         end
      join_none
      @(negedge clk);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      chk_en = 1'b1;
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_data", 32'(data_out), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);

      // len=8, 1011_0010: valid exactly one cycle after the 8th sample.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, (8'hB2 >> (7 - i)) & 1'b1, 4'd8, 1'b1);
         if (i == 6) chk("len8_not_early", 32'(valid), 32'd0);
      end
      chk("len8_valid", 32'(valid), 32'd1);
      chk("len8_data", 32'(data_out), 32'hB200);
      step(1'b1, 1'b0, 1'b0, 4'd8, 1'b1);
      chk("len8_one_cycle", 32'(valid), 32'd0);

      // Full-width frame and single-bit frame.
      frame(4'd0, 16'hA5C3, 16, 1'b1);
      chk("len16_data", 32'(data_out), 32'hA5C3);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 4'd1, 1'b1);
      chk("len1_valid", 32'(valid), 32'd1);
      chk("len1_data", 32'(data_out), 32'h8000);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

      // Aborted frame is discarded.
      frame(4'd8, 16'hFFFF, 5, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'd8, 1'b1);
      chk("abort_no_word", 32'(valid), 32'd0);
      frame(4'd4, 16'hF000, 4, 1'b1);
      chk("after_abort_data", 32'(data_out), 32'hF000);
      chk("after_abort_ovf", 32'(overrun), 32'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

      // Overrun with ready low across two completions.
      frame(4'd4, 16'hA000, 4, 1'b0);
      frame(4'd4, 16'h5000, 4, 1'b0);
      chk("ovr_data", 32'(data_out), 32'hA000);
      chk("ovr_flag", 32'(overrun), 32'd1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("ovr_accept_valid", 32'(valid), 32'd0);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Simultaneous accept and completion.
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      frame(4'd4, 16'hA000, 4, 1'b0);
      step(1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
      step(1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
      chk("simul_valid", 32'(valid), 32'd1);
      chk("simul_data", 32'(data_out), 32'hC000);
      chk("simul_ovf", 32'(overrun), 32'd0);

      // Reset mid-frame while a word is held.
      step(1'b1, 1'b1, 1'b1, 4'd4, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_data", 32'(data_out), 32'd0);
      chk("midrst_ovf", 32'(overrun), 32'd0);
      frame(4'd2, 16'hC000, 2, 1'b1);
      chk("post_rst_data", 32'(data_out), 32'hC000);

      // Randomized traffic; the per-cycle monitor carries the checking.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 99) < 85),
              1'($urandom),
              4'($urandom),
              ($urandom_range(0, 99) < 60));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
